// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide engine that sits beside the EX-stage ALU.
// One shift-add or restoring-divide step is done per clock on operand
// magnitudes, and the sign is fixed up when the result is loaded. The
// pipeline is stalled while the op runs. The result is registered with its
// rd tag and is valid for one cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            word_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned HX = XLEN / 2;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          f3_q;
  logic                word_q;
  logic [4:0]          rd_q;
  logic                neg_q;
  logic                rneg_q;
  logic [XLEN-1:0]     a_q;
  logic [2*XLEN-1:0]   p_q;

  // Decode of the op presented in EX
  logic                is_div, w_eff, sgn1, sgn2, neg1, neg2;
  logic                div0, ovf, accept, special;
  logic [XLEN-1:0]     e1, e2, mag1, mag2, dvd_sx, min_val, spec_res, init_a;
  logic [2*XLEN-1:0]   init_p;

  // Iteration datapath
  logic                run, st_div;
  logic [XLEN-1:0]     st_a;
  logic [2*XLEN-1:0]   st_p, p_next;
  logic [XLEN:0]       mul_sum, rem_sh, rem_diff;

  // Result assembly
  logic [2*XLEN-1:0]   prod_f;
  logic [XLEN-1:0]     quo_f, rem_f, fin_v, fin_res;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{HX{v[HX-1]}}, v[HX-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    return {{HX{1'b0}}, v[HX-1:0]};
  endfunction

  // Operand signedness, magnitudes, special-case detection and initial step state
  always_comb begin
    is_div = funct3_i[2];
    // word_i only matters for MULW and the divide family
    w_eff  = word_i & (is_div | (funct3_i[1:0] == 2'b00));
    // MULW keeps only the low half of the product, which is sign-agnostic,
    // so it runs as an unsigned multiply with no sign fix-up
    if (is_div) begin
      sgn1 = ~funct3_i[0];
      sgn2 = ~funct3_i[0];
    end else begin
      sgn1 = ~(funct3_i[1] & funct3_i[0]) & ~w_eff;
      sgn2 = ~funct3_i[1] & ~w_eff;
    end
    e1 = op1_i;
    e2 = op2_i;
    if (w_eff) begin
      e1 = sgn1 ? sext_w(op1_i) : zext_w(op1_i);
      e2 = sgn2 ? sext_w(op2_i) : zext_w(op2_i);
    end
    neg1    = sgn1 & e1[XLEN-1];
    neg2    = sgn2 & e2[XLEN-1];
    mag1    = neg1 ? ('0 - e1) : e1;
    mag2    = neg2 ? ('0 - e2) : e2;
    dvd_sx  = w_eff ? sext_w(op1_i) : op1_i;
    min_val = w_eff ? {{(HX+1){1'b1}}, {(HX-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = is_div & (e2 == '0);
    ovf     = is_div & ~funct3_i[0] & (e1 == min_val) & (e2 == '1);
    special = div0 | ovf;
    if (div0)
      spec_res = funct3_i[1] ? dvd_sx : '1;
    else
      spec_res = funct3_i[1] ? '0 : dvd_sx;
    init_a = is_div ? mag2 : mag1;
    if (!is_div)
      init_p = {{XLEN{1'b0}}, mag2};
    else if (w_eff)
      init_p = {{XLEN{1'b0}}, mag1[HX-1:0], {HX{1'b0}}};
    else
      init_p = {{XLEN{1'b0}}, mag1};
    accept = (state_q == IDLE) & start_i & ~flush_i;
  end

  // One multiply or divide iteration; the accepting edge runs the first one
  // on freshly decoded operands, RUN edges continue from the registers
  always_comb begin
    run      = (state_q == RUN);
    st_div   = run ? f3_q[2] : is_div;
    st_a     = run ? a_q : init_a;
    st_p     = run ? p_q : init_p;
    mul_sum  = {1'b0, st_p[2*XLEN-1:XLEN]} + ({(XLEN+1){st_p[0]}} & {1'b0, st_a});
    rem_sh   = {st_p[2*XLEN-1:XLEN], st_p[XLEN-1]};
    rem_diff = rem_sh - {1'b0, st_a};
    if (!st_div)
      p_next = {mul_sum, st_p[XLEN-1:1]};
    else if (!rem_diff[XLEN])
      p_next = {rem_diff[XLEN-1:0], st_p[XLEN-2:0], 1'b1};
    else
      p_next = {rem_sh[XLEN-1:0], st_p[XLEN-2:0], 1'b0};
  end

  // Sign correction and half/quotient/remainder selection for the final step
  always_comb begin
    prod_f = neg_q ? ('0 - p_next) : p_next;
    quo_f  = neg_q ? ('0 - p_next[XLEN-1:0]) : p_next[XLEN-1:0];
    rem_f  = rneg_q ? ('0 - p_next[2*XLEN-1:XLEN]) : p_next[2*XLEN-1:XLEN];
    if (f3_q[2])
      fin_v = f3_q[1] ? rem_f : quo_f;
    else if (word_q)
      // after HX steps the 2*HX-bit product sits at p[XLEN+HX-1:HX]
      fin_v = {{HX{1'b0}}, p_next[XLEN-1:HX]};
    else if (f3_q[1:0] == 2'b00)
      fin_v = prod_f[XLEN-1:0];
    else
      fin_v = prod_f[2*XLEN-1:XLEN];
    fin_res = word_q ? sext_w(fin_v) : fin_v;
  end

  // Next-state and pipeline handshake outputs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
    stall_o = accept | ((state_q == RUN) & ~flush_i);
    busy_o  = (state_q == RUN);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand latching, iteration registers and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      word_q   <= 1'b0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      a_q      <= '0;
      p_q      <= '0;
      valid_o  <= 1'b0;
      rd_o     <= '0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        f3_q   <= funct3_i;
        word_q <= w_eff;
        rd_q   <= rd_i;
        neg_q  <= neg1 ^ neg2;
        rneg_q <= neg1;
        if (special) begin
          result_o <= spec_res;
          rd_o     <= rd_i;
          valid_o  <= 1'b1;
        end else begin
          a_q   <= init_a;
          p_q   <= p_next;
          // the first iteration happens on this edge, so the counter holds
          // the number of RUN iterations still to go after it, minus one
          cnt_q <= w_eff ? CW'(HX - 2) : CW'(XLEN - 2);
        end
      end else if ((state_q == RUN) && !flush_i) begin
        p_q   <= p_next;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_o <= fin_res;
          rd_o     <= rd_q;
          valid_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results go into a scoreboard
// queue when an op is issued and are popped when valid_o appears.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, flush_i, word_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [63:0] op1_i, op2_i;
  logic        stall_o, busy_o, valid_o;
  logic [4:0]  rd_o;
  logic [63:0] result_o;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  muldiv_unit #(.XLEN(64)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .word_i   (word_i),
    .funct3_i (funct3_i),
    .rd_i     (rd_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .rd_o     (rd_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op at posedge+1 (cycle 0), hold start_i through the DONE
  // cycle, then watch a few idle cycles for stray pulses.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input bit scramble);
    exp_t e;
    int   stalls = 0;
    int   pulses = 0;
    e.rd = rd; e.res = exp; e.lat = lat;
    sb.push_back(e);
    last_res = exp;
    last_rd  = rd;
    start_i = 1'b1; funct3_i = f3; word_i = w; rd_i = rd; op1_i = a; op2_i = b;
    for (int cyc = 0; cyc <= lat + 3; cyc++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (valid_o) begin
        pulses++;
        if (sb.size() == 0) begin
          chk({tag, "_extra_valid"}, 64'(cyc), 64'(lat));
        end else begin
          e = sb.pop_front();
          chk({tag, "_result"}, result_o, e.res);
          chk({tag, "_rd"}, 64'(rd_o), 64'(e.rd));
          chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        end
      end
      @(posedge clk_i); #1;
      if (cyc == lat) start_i = 1'b0;
      if (scramble && cyc == 0) begin op1_i = ~a; op2_i = 64'h3; end
    end
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int pulses;
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; word_i = 1'b0;
    funct3_i = '0; rd_i = '0; op1_i = '0; op2_i = '0;
    #1;
    chk("rst_valid",  64'(valid_o), 64'd0);
    chk("rst_busy",   64'(busy_o),  64'd0);
    chk("rst_stall",  64'(stall_o), 64'd0);
    chk("rst_rd",     64'(rd_o),    64'd0);
    chk("rst_result", result_o,     64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 64-bit multiplies
    run_op("mul",    3'b000, 1'b0, 5'd5,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b0);
    run_op("mulh",   3'b001, 1'b0, 5'd6,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64, 1'b0);
    run_op("mulhu",  3'b011, 1'b0, 5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b0);
    run_op("mulhsu", 3'b010, 1'b0, 5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
    run_op("mulhu_w_ignored", 3'b011, 1'b1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64, 1'b0);
    run_op("mulw",   3'b000, 1'b1, 5'd10, 64'h0000_0001_0000_0003, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0);

    // Divide-by-zero and overflow shortcuts
    run_op("divu_by0", 3'b101, 1'b0, 5'd11, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    run_op("remu_by0", 3'b111, 1'b0, 5'd12, 64'd100, 64'd0, 64'd100, 1, 1'b0);
    run_op("div_ovf",  3'b100, 1'b0, 5'd13, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1'b0);
    run_op("rem_ovf",  3'b110, 1'b0, 5'd14, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0);
    run_op("remuw_by0", 3'b111, 1'b1, 5'd15, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0, 1, 1'b0);
    run_op("divw_ovf", 3'b100, 1'b1, 5'd16, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);

    // Word divides
    run_op("divw",  3'b100, 1'b1, 5'd17, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0);
    run_op("remw",  3'b110, 1'b1, 5'd18, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b0);
    run_op("divuw", 3'b101, 1'b1, 5'd19, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 32, 1'b0);

    // 64-bit divides, operands changed after the start cycle
    run_op("div_latch", 3'b100, 1'b0, 5'd20, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b1);
    run_op("rem_latch", 3'b110, 1'b0, 5'd21, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
    run_op("divu", 3'b101, 1'b0, 5'd22, 64'd100, 64'd7, 64'd14, 64, 1'b0);
    run_op("remu", 3'b111, 1'b0, 5'd23, 64'd100, 64'd7, 64'd2, 64, 1'b0);

    // Flush in cycle 10 of a DIV
    start_i = 1'b1; funct3_i = 3'b100; word_i = 1'b0; rd_i = 5'd30;
    op1_i = 64'd1000; op2_i = 64'd3;
    repeat (10) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_busy_before", 64'(busy_o), 64'd1);
    chk("flush_stall", 64'(stall_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; start_i = 1'b0;
    chk("flush_busy_after", 64'(busy_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_i);
      if (valid_o) pulses++;
    end
    chk("flush_no_valid", 64'(pulses), 64'd0);
    chk("flush_result_held", result_o, last_res);
    chk("flush_rd_held", 64'(rd_o), 64'(last_rd));
    @(posedge clk_i); #1;
    run_op("mul_after_flush", 3'b000, 1'b0, 5'd24, 64'd3, 64'd4, 64'd12, 64, 1'b0);

    // Reset in the middle of RUN
    start_i = 1'b1; funct3_i = 3'b000; word_i = 1'b0; rd_i = 5'd25;
    op1_i = 64'd5; op2_i = 64'd6;
    repeat (5) begin @(posedge clk_i); #1; end
    rst_i = 1'b1; start_i = 1'b0;
    #1;
    chk("midrst_valid",  64'(valid_o), 64'd0);
    chk("midrst_busy",   64'(busy_o),  64'd0);
    chk("midrst_stall",  64'(stall_o), 64'd0);
    chk("midrst_rd",     64'(rd_o),    64'd0);
    chk("midrst_result", result_o,     64'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
